// File: rtl/chess_ctrl_pkg.sv
// Shared constants and types for the LMG sequencer: register map layout,
// board and move widths, and the sequencer state encoding.
package chess_ctrl_pkg;

  localparam int CTRL_ADDR     = 0;
  localparam int BOARD_BASE    = 2;
  localparam int BOARD_WORDS   = 8;
  localparam int RESULT_BASE   = 16;
  localparam int RESULT_STRIDE = 8;
  localparam int RESULT_WORDS  = 5;
  localparam int LMG_MOVE_BITS = 152;
  localparam int BOARD_BITS    = 256;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_KICK,
    ST_RUN,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/lmg_result_ram.sv
// Move result store: one write port fed by the LMG drain, one registered
// read port returning a selected 32-bit word of a zero-extended row.
module lmg_result_ram #(
  parameter int DEPTH  = 64,
  parameter int WIDTH  = 152,
  parameter int AW     = 6,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  input  logic [2:0]        i_wsel,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [WIDTH-1:0]    r_row;
  logic [2:0]          r_wsel;
  logic [8*WORD_W-1:0] w_row;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Row and select are registered together so the array maps onto block RAM;
  // words beyond the move width fall into the zero padding.
  always_ff @(posedge clk) begin
    if (i_re) begin
      r_row  <= r_mem[i_raddr];
      r_wsel <= i_wsel;
    end
  end

  assign w_row   = {{(8*WORD_W-WIDTH){1'b0}}, r_row};
  assign o_rdata = w_row[r_wsel*WORD_W +: WORD_W];

endmodule

// File: rtl/lmg_sequencer.sv
// Avalon-MM sequencer for the legal move generator: holds the board, kicks
// the LMG, drains its move FIFO into the result RAM and reports status.
module lmg_sequencer
  import chess_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 15,
  parameter int MAX_MOVES  = 64,
  parameter int MOVE_BITS  = LMG_MOVE_BITS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   slave_address,
  input  logic                    slave_read,
  input  logic                    slave_write,
  input  logic [DATA_WIDTH-1:0]   slave_writedata,
  input  logic [DATA_WIDTH/8-1:0] slave_byteenable,
  output logic [DATA_WIDTH-1:0]   slave_readdata,
  output logic [BOARD_BITS-1:0]   lmgBoard,
  output logic                    lmgReset,
  input  logic                    lmgDone,
  input  logic [MOVE_BITS-1:0]    lmgFifoOut,
  input  logic                    lmgFifoEmpty,
  output logic                    lmgFifoRead
);

  localparam int RA_W      = (MAX_MOVES > 1) ? $clog2(MAX_MOVES) : 1;
  localparam int CNT_W     = 8;
  localparam int STRIDE_SH = $clog2(RESULT_STRIDE);

  seq_state_e             r_state;
  logic [CNT_W-1:0]       r_count;
  logic                   r_done;
  logic                   r_ovf;
  logic                   r_lmg_reset;
  logic [DATA_WIDTH-1:0]  r_board [BOARD_WORDS];
  logic [DATA_WIDTH-1:0]  r_rdata;
  logic                   r_rd_ram;

  logic                   w_busy;
  logic                   w_wr_ctrl;
  logic                   w_start;
  logic                   w_clear;
  logic [ADDR_WIDTH-1:0]  w_board_off;
  logic                   w_is_board;
  logic [2:0]             w_board_idx;
  logic [ADDR_WIDTH-1:0]  w_res_off;
  logic [ADDR_WIDTH-1:0]  w_res_row;
  logic [2:0]             w_res_word;
  logic                   w_is_res;
  logic                   w_ram_we;
  logic                   w_ram_re;
  logic [DATA_WIDTH-1:0]  w_ram_word;
  logic [DATA_WIDTH-1:0]  w_status;
  logic                   w_unused_be;

  // Every write is a full word, so byte enables carry no information.
  assign w_unused_be = ^slave_byteenable;

  assign w_busy    = (r_state == ST_KICK) || (r_state == ST_RUN);
  assign w_wr_ctrl = slave_write && (slave_address == ADDR_WIDTH'(CTRL_ADDR));
  assign w_start   = w_wr_ctrl && slave_writedata[0] && !w_busy;
  assign w_clear   = w_wr_ctrl && slave_writedata[1] && !w_busy;

  // Unsigned wrap of the offsets makes addresses below each base fail the range test.
  assign w_board_off = slave_address - ADDR_WIDTH'(BOARD_BASE);
  assign w_is_board  = w_board_off < ADDR_WIDTH'(BOARD_WORDS);
  assign w_board_idx = w_board_off[2:0];

  assign w_res_off  = slave_address - ADDR_WIDTH'(RESULT_BASE);
  assign w_res_row  = w_res_off >> STRIDE_SH;
  assign w_res_word = w_res_off[2:0];
  assign w_is_res   = (slave_address >= ADDR_WIDTH'(RESULT_BASE)) &&
                      (w_res_row < ADDR_WIDTH'(MAX_MOVES)) &&
                      (w_res_word < 3'(RESULT_WORDS));

  assign w_status = {{(DATA_WIDTH-16){1'b0}}, r_count, 5'b0, r_ovf, r_done, w_busy};

  assign lmgFifoRead = (r_state == ST_RUN) && !lmgFifoEmpty;
  assign lmgReset    = r_lmg_reset;
  assign w_ram_we    = lmgFifoRead && (r_count < CNT_W'(MAX_MOVES));
  assign w_ram_re    = slave_read && w_is_res;

  lmg_result_ram #(
    .DEPTH  (MAX_MOVES),
    .WIDTH  (MOVE_BITS),
    .AW     (RA_W),
    .WORD_W (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (r_count[RA_W-1:0]),
    .i_wdata (lmgFifoOut),
    .i_re    (w_ram_re),
    .i_raddr (w_res_row[RA_W-1:0]),
    .i_wsel  (w_res_word),
    .o_rdata (w_ram_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
      r_lmg_reset <= 1'b0;
    end else begin
      r_lmg_reset <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start) begin
            r_state     <= ST_KICK;
            r_count     <= '0;
            r_done      <= 1'b0;
            r_ovf       <= 1'b0;
            r_lmg_reset <= 1'b1;
          end else if (w_clear) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
          end
        end
        ST_KICK: begin
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (lmgFifoRead) begin
            if (r_count < CNT_W'(MAX_MOVES)) begin
              r_count <= r_count + CNT_W'(1);
            end else begin
              r_ovf <= 1'b1;
            end
          end
          // Finish only once the FIFO is drained, even if lmgDone came early.
          if (lmgDone && lmgFifoEmpty) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < BOARD_WORDS; k++) begin
        r_board[k] <= '0;
      end
    end else if (slave_write && w_is_board && !w_busy) begin
      r_board[w_board_idx] <= slave_writedata;
    end
  end

  always_comb begin
    lmgBoard = '0;
    for (int k = 0; k < BOARD_WORDS; k++) begin
      lmgBoard[k*DATA_WIDTH +: DATA_WIDTH] = r_board[k];
    end
  end

  // Non-RAM reads land in r_rdata; RAM reads come from the RAM's own output
  // register, selected by r_rd_ram, so both paths have one cycle of latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata  <= '0;
      r_rd_ram <= 1'b0;
    end else if (slave_read) begin
      r_rd_ram <= w_is_res;
      if (slave_address == ADDR_WIDTH'(CTRL_ADDR)) begin
        r_rdata <= w_status;
      end else if (w_is_board) begin
        r_rdata <= r_board[w_board_idx];
      end else begin
        r_rdata <= '0;
      end
    end
  end

  assign slave_readdata = r_rd_ram ? w_ram_word : r_rdata;

endmodule

// File: tb/tb_lmg_sequencer.sv
// Directed bench for lmg_sequencer: a behavioural FIFO/board/result model is
// compared against the DUT every cycle, plus literal register readbacks.
module tb_lmg_sequencer;

  localparam int MAXM = 4;
  localparam int MB   = 152;

  logic         clk = 1'b0;
  logic         reset;
  logic [14:0]  slave_address;
  logic         slave_read;
  logic         slave_write;
  logic [31:0]  slave_writedata;
  logic [3:0]   slave_byteenable;
  logic [31:0]  slave_readdata;
  logic [255:0] lmgBoard;
  logic         lmgReset;
  logic         lmgDone;
  logic [MB-1:0] lmgFifoOut;
  logic         lmgFifoEmpty;
  logic         lmgFifoRead;

  always #5 clk = ~clk;

  lmg_sequencer #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (15),
    .MAX_MOVES  (MAXM),
    .MOVE_BITS  (MB)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .slave_address    (slave_address),
    .slave_read       (slave_read),
    .slave_write      (slave_write),
    .slave_writedata  (slave_writedata),
    .slave_byteenable (slave_byteenable),
    .slave_readdata   (slave_readdata),
    .lmgBoard         (lmgBoard),
    .lmgReset         (lmgReset),
    .lmgDone          (lmgDone),
    .lmgFifoOut       (lmgFifoOut),
    .lmgFifoEmpty     (lmgFifoEmpty),
    .lmgFifoRead      (lmgFifoRead)
  );

  int nvec = 0;
  int nerr = 0;

  // Model state: what software should observe, kept in plain terms.
  logic [31:0]   m_board [8];
  logic [MB-1:0] m_mem [MAXM];
  bit            m_kick, m_run, m_done, m_cleared;
  int            run_pops;
  int            pop_cnt = 0;
  int            rst_pulses = 0;
  logic [MB-1:0] fifo_q [$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    int cnt;
    bit ovf;
    cnt = (run_pops < MAXM) ? run_pops : MAXM;
    ovf = (run_pops > MAXM) && !m_cleared;
    return {16'h0, 8'(cnt), 5'b0, ovf, m_done, (m_kick || m_run)};
  endfunction

  function automatic logic [31:0] m_read(input int a);
    logic [159:0] row;
    int off, m, w;
    if (a == 0) return m_status();
    if (a >= 2 && a <= 9) return m_board[a-2];
    if (a >= 16) begin
      off = a - 16;
      m   = off / 8;
      w   = off % 8;
      if (m < MAXM && w < 5) begin
        row = {8'h0, m_mem[m]};
        return row[w*32 +: 32];
      end
    end
    return 32'h0;
  endfunction

  // Compare process and FIFO environment. Outputs are checked mid-cycle; the
  // model then advances to what the next rising edge must produce.
  initial begin
    logic [255:0] mb;
    bit busy, pend;
    lmgFifoEmpty = 1'b1;
    lmgFifoOut   = '0;
    pend         = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_kick = 0; m_run = 0; m_done = 0; m_cleared = 0; run_pops = 0;
        for (int k = 0; k < 8; k++) m_board[k] = 32'h0;
        pend = 1'b0;
      end else begin
        for (int k = 0; k < 8; k++) mb[32*k +: 32] = m_board[k];
        chk("lmgBoard", lmgBoard, mb);
        chk("lmgReset", lmgReset, m_kick);
        chk("lmgFifoRead", lmgFifoRead, m_run && !lmgFifoEmpty);
        if (lmgReset) rst_pulses++;
        pend = lmgFifoRead;
        busy = m_kick || m_run;
        if (m_run && !lmgFifoEmpty) begin
          if (run_pops < MAXM) m_mem[run_pops] = lmgFifoOut;
          run_pops++;
        end
        if (m_run && lmgDone && lmgFifoEmpty) begin
          m_run  = 0;
          m_done = 1;
        end
        if (m_kick) begin
          m_kick = 0;
          m_run  = 1;
        end
        if (slave_write && !busy) begin
          if (slave_address >= 2 && slave_address <= 9)
            m_board[slave_address-2] = slave_writedata;
          if (slave_address == 0 && slave_writedata[0]) begin
            m_kick = 1; m_done = 0; m_cleared = 0; run_pops = 0;
          end else if (slave_address == 0 && slave_writedata[1]) begin
            m_done = 0; m_cleared = 1;
          end
        end
      end
      @(posedge clk);
      #1;
      if (pend && fifo_q.size() > 0) begin
        fifo_q.delete(0);
        pop_cnt++;
      end
      lmgFifoEmpty = (fifo_q.size() == 0);
      lmgFifoOut   = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    end
  end

  // Stimulus runs 2 time units after each rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    slave_address   = 15'(a);
    slave_writedata = d;
    slave_write     = 1'b1;
    tick(1);
    slave_write = 1'b0;
  endtask

  task automatic rd(input int a, output logic [31:0] q);
    logic [31:0] exp;
    exp           = m_read(a);
    slave_address = 15'(a);
    slave_read    = 1'b1;
    tick(1);
    slave_read = 1'b0;
    q = slave_readdata;
    chk($sformatf("read_addr%0d", a), q, exp);
  endtask

  task automatic rdwr(input int a, input logic [31:0] d, output logic [31:0] q);
    logic [31:0] exp;
    exp             = m_read(a);
    slave_address   = 15'(a);
    slave_writedata = d;
    slave_read      = 1'b1;
    slave_write     = 1'b1;
    tick(1);
    slave_read  = 1'b0;
    slave_write = 1'b0;
    q = slave_readdata;
    chk($sformatf("rdwr_addr%0d", a), q, exp);
  endtask

  task automatic push(input int k);
    logic [3:0] nib;
    nib = 4'(k);
    fifo_q.push_back({38{nib}});
  endtask

  task automatic wait_pops(input int target);
    int t;
    t = 0;
    while (pop_cnt < target && t < 200) begin
      tick(1);
      t++;
    end
    chk("pops_reached", pop_cnt, target);
  endtask

  initial begin
    logic [31:0] q;
    int base, p0;
    reset = 1'b1;
    slave_address = '0; slave_read = 0; slave_write = 0;
    slave_writedata = '0; slave_byteenable = '1; lmgDone = 0;
    tick(3);
    chk("rst_readdata", slave_readdata, 0);
    chk("rst_lmgReset", lmgReset, 0);
    chk("rst_fiforead", lmgFifoRead, 0);
    chk("rst_board", lmgBoard, 0);
    reset = 1'b0;
    tick(1);
    rd(0, q); chk("status_idle", q, 32'h0);

    // Board load and readback
    wr(2, 32'h23465432);
    for (int k = 3; k <= 9; k++) wr(k, 32'h0);
    chk("board_lo", lmgBoard[31:0], 32'h23465432);
    chk("board_hi", lmgBoard[255:32], 0);
    rd(2, q); chk("board_rd", q, 32'h23465432);
    rd(1, q); chk("unmapped1", q, 32'h0);
    rd(12, q);

    // Basic run: three moves
    push(1); push(2); push(3);
    tick(2);
    base = pop_cnt; p0 = rst_pulses;
    wr(0, 32'h1);
    wait_pops(base + 3);
    lmgDone = 1'b1;
    tick(4);
    chk("basic_kicks", rst_pulses - p0, 1);
    rd(0, q);  chk("basic_status", q, 32'h0302);
    rd(16, q); chk("m0w0", q, 32'h11111111);
    rd(17, q); rd(18, q); rd(19, q);
    rd(20, q); chk("m0w4", q, 32'h00111111);
    rd(21, q); chk("m0w5", q, 32'h0);
    rd(23, q); chk("m0w7", q, 32'h0);
    rd(24, q); chk("m1w0", q, 32'h22222222);
    rd(32, q); chk("m2w0", q, 32'h33333333);
    rd(48, q); chk("m4_beyond", q, 32'h0);

    // Read and write of the same register on one cycle
    rdwr(4, 32'hCAFEF00D, q); chk("rdwr_old", q, 32'h0);
    rd(4, q); chk("rdwr_new", q, 32'hCAFEF00D);

    // Overflow: six moves into four rows
    lmgDone = 1'b0;
    for (int k = 4; k <= 9; k++) push(k);
    tick(2);
    base = pop_cnt;
    wr(0, 32'h1);
    wait_pops(base + 6);
    lmgDone = 1'b1;
    tick(4);
    rd(0, q);  chk("ovf_status", q, 32'h0406);
    rd(16, q); chk("ovf_m0", q, 32'h44444444);
    rd(40, q); chk("ovf_m3", q, 32'h77777777);
    wr(0, 32'h2);
    rd(0, q);  chk("clear_status", q, 32'h0400);

    // lmgDone already high with moves queued
    push(10); push(11);
    tick(2);
    base = pop_cnt;
    wr(0, 32'h1);
    wait_pops(base + 2);
    tick(4);
    rd(0, q);  chk("early_done_status", q, 32'h0202);
    rd(24, q); chk("early_done_m1", q, 32'hBBBBBBBB);

    // Start and board writes while busy are ignored
    lmgDone = 1'b0;
    p0 = rst_pulses;
    wr(0, 32'h1);
    tick(3);
    wr(0, 32'h1);
    wr(3, 32'hFFFFFFFF);
    chk("busy_board_w1", lmgBoard[63:32], 32'h0);
    chk("busy_board_w2", lmgBoard[95:64], 32'hCAFEF00D);
    base = pop_cnt;
    push(12); push(13);
    wait_pops(base + 2);
    lmgDone = 1'b1;
    tick(4);
    chk("busy_kicks", rst_pulses - p0, 1);
    rd(0, q); chk("busy_status", q, 32'h0202);
    rd(3, q); chk("busy_board_rd", q, 32'h0);

    // Asynchronous reset in the middle of a run
    lmgDone = 1'b0;
    wr(0, 32'h1);
    tick(3);
    base = pop_cnt;
    push(14); push(15);
    wait_pops(base + 1);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_readdata", slave_readdata, 32'h0);
    chk("arst_fiforead", lmgFifoRead, 0);
    chk("arst_lmgReset", lmgReset, 0);
    tick(2);
    reset = 1'b0;
    fifo_q.delete();
    tick(2);
    rd(0, q); chk("arst_status", q, 32'h0);
    chk("arst_board", lmgBoard, 0);
    push(13); push(14);
    tick(2);
    base = pop_cnt;
    wr(0, 32'h1);
    wait_pops(base + 2);
    lmgDone = 1'b1;
    tick(4);
    rd(0, q);  chk("fresh_status", q, 32'h0202);
    rd(16, q); chk("fresh_m0", q, 32'hDDDDDDDD);
    rd(24, q); chk("fresh_m1", q, 32'hEEEEEEEE);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lmg_sequencer.md
# lmg_sequencer

Avalon-MM–mapped sequencer for the legal move generator (LMG). It latches a 256-bit board state from the HPS and launches the LMG. It drains the LMG's move FIFO into an internal result RAM and reports busy, done, overflow and move count for software polling. It sits between the Qsys slave port and the LMG datapath, replacing the ad-hoc control path.

## Interface
- DATA_WIDTH, 32, slave data width.
- ADDR_WIDTH, 15, slave word-address width.
- MAX_MOVES, 64, result RAM depth in moves (1..255).
- MOVE_BITS, 152, width of one LMG FIFO entry.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- slave_address  in  ADDR_WIDTH  word address.
- slave_read  in  1  read strobe.
- slave_write  in  1  write strobe.
- slave_writedata  in  DATA_WIDTH  write data.
- slave_byteenable  in  DATA_WIDTH/8  ignored; every write is a full word.
- slave_readdata  out  DATA_WIDTH  registered read data.
- lmgBoard  out  256  board state to LMG; word k (addr 2+k) drives bits [32k+31:32k].
- lmgReset  out  1  one-cycle LMG restart pulse.
- lmgDone  in  1  LMG finished generating; level.
- lmgFifoOut  in  MOVE_BITS  show-ahead FIFO head; valid when lmgFifoEmpty=0.
- lmgFifoEmpty  in  1  FIFO empty.
- lmgFifoRead  out  1  pop strobe, one entry per cycle asserted.

## Operation
- Register map:
  - addr 0, write: bit0=1 starts a run; bit1=1 clears done/overflow.
  - addr 0, read: bit0 busy, bit1 done, bit2 overflow, bits[15:8] moveCount; other bits 0.
  - addrs 2..9: board words, read/write.
  - addr 16+8m+w, w=0..4: move m, bits [32w+31:32w] zero-extended to 160 bits.
  - w=5..7 reads 0; m≥MAX_MOVES reads 0; unmapped reads 0; unmapped writes ignored.
- Board writes while busy are ignored. Start while busy is ignored.
- FSM states: IDLE, KICK, RUN, DONE.
  - IDLE: start → KICK. The transition clears moveCount, done and overflow.
  - KICK: lmgReset=1 for exactly one cycle → RUN.
  - RUN: when lmgFifoEmpty=0, assert lmgFifoRead combinationally in that cycle.
    - If moveCount<MAX_MOVES, write lmgFifoOut to row moveCount and increment moveCount.
    - Otherwise discard the entry and set overflow. moveCount saturates at MAX_MOVES.
    - When lmgDone=1 and lmgFifoEmpty=1 in the same cycle → DONE.
    - lmgDone=1 with a non-empty FIFO keeps draining.
  - DONE: done=1, busy=0. A start → KICK, same clearing as IDLE. A clear → IDLE.
- busy=1 in KICK and RUN.
- Reset:
  - FSM → IDLE. moveCount, done, overflow, lmgReset, lmgFifoRead and slave_readdata → 0.
  - Board registers → 0.
  - Result RAM contents are not cleared.
  - Reset mid-run abandons the run; the LMG is restarted by the next KICK.

## Timing
- Read latency 1: slave_readdata is valid on the cycle after a slave_read sample and holds until the next read.
- Read and write on the same cycle: the write commits, and the read returns the pre-write value.
- Start to lmgReset pulse: lmgReset is high in the cycle after the write of bit0=1 is sampled.
- First pop is possible in the cycle after KICK.
- Drain rate is 1 move/cycle. moveCount updates the cycle after the pop.
- done rises one cycle after the lmgDone && empty cycle.
- A status read issued on the cycle done rises returns busy=1.

## Structure
- Package chess_ctrl_pkg holds:
  - address constants: CTRL_ADDR=0, BOARD_BASE=2, RESULT_BASE=16, RESULT_STRIDE=8;
  - the FSM state enum;
  - MOVE_BITS and board width 256.
- One sub-module, lmg_result_ram: MAX_MOVES×MOVE_BITS, one write port, one registered read port with a 3-bit word select. It is inferable as M10K.

## Test plan
- Board load: write 0x23465432 to addr 2 and 0 to addrs 3..9 → lmgBoard[31:0]=0x23465432, upper bits 0; readback of addr 2 matches after one cycle.
- Basic run: start; FIFO presents 3 entries (0x1…, 0x2…, 0x3…) then lmgDone → exactly one lmgReset pulse and 3 lmgFifoRead cycles. Status reads 0x0302. Addr 16..20 return entry 0; addr 24 returns entry 1 word 0; addr 21 returns 0.
- Overflow: MAX_MOVES=4, 6 entries → moveCount=4, overflow=1, all 6 popped; status 0x0406.
- Done with non-empty FIFO: lmgDone high from the start with 2 entries queued → both drained before done; count 2.
- Start ignored while busy: start written during RUN → no second lmgReset pulse; board write of 0xFFFFFFFF to addr 3 during RUN → lmgBoard unchanged.
- Async reset mid-RUN → status 0 immediately, lmgFifoRead=0; a new start gives a fresh run with count from 0.
